// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and helpers for the PWM controller.
//   DUTY_W      - width of the duty_cycle request (duty = duty_cycle/256)
//   clog2_min1  - minimum counter width able to hold value-1, never below 1
package pwm_pkg;

  localparam int DUTY_W = 8;

  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << w) < 64'(value)) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage : pwm_pkg

// File: rtl/pwm_controller_if.sv
// pwm_controller_if: control/output bundle of the PWM controller.
//   enable     - runs the PWM when 1; output low and counter held at 0 when 0
//   duty_cycle - requested duty as unsigned fraction duty_cycle/256
//   pwm_out    - registered PWM waveform
// Handshake: none; enable and duty_cycle are level signals sampled on every
// rising clk edge, pwm_out is a registered level with one cycle of latency.
interface pwm_controller_if;
  import pwm_pkg::*;

  logic              enable;
  logic [DUTY_W-1:0] duty_cycle;
  logic              pwm_out;

  modport master (output enable, output duty_cycle, input pwm_out);
  modport slave  (input enable, input duty_cycle, output pwm_out);

endinterface : pwm_controller_if

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running period counter 0..PERIOD-1.
//   clk, rst   - clock, asynchronous active-high reset
//   i_enable   - counts when 1, cleared to 0 on every clk when 0
//   o_count    - current counter value
//   o_zero     - high while the counter is 0 (period boundary)
module pwm_period_counter #(
  parameter int PERIOD = 10,
  parameter int CW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_enable,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  logic [CW-1:0] r_count;
  logic          w_terminal;

  assign w_terminal = (r_count == CW'(PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_enable || w_terminal) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule : pwm_period_counter

// File: rtl/pwm_controller.sv
// pwm_controller: fixed-frequency PWM generator.
//   clk, rst     - clock, asynchronous active-high reset
//   bus          - slave side of pwm_controller_if (enable, duty_cycle, pwm_out)
//   o_dbg_count  - period counter value, for observation
// PERIOD = CLK_FREQ/PWM_FREQ cycles; each period holds exactly
// floor(duty*PERIOD/256) high cycles followed by the remaining low cycles.
module pwm_controller
  import pwm_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int PWM_FREQ = 1_000,
  localparam int PERIOD  = CLK_FREQ / PWM_FREQ,
  localparam int CW      = clog2_min1(PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  pwm_controller_if.slave  bus,
  output logic [CW-1:0]    o_dbg_count
);

  localparam int PW = DUTY_W + CW;

  if (PERIOD < 2) begin : g_bad_period
    $error("pwm_controller: CLK_FREQ/PWM_FREQ must be at least 2");
  end

  logic [CW-1:0]     w_count;
  logic              w_zero;
  logic [DUTY_W-1:0] r_duty_shadow;
  logic [DUTY_W-1:0] w_duty_eff;
  logic [PW-1:0]     w_product;
  logic [CW-1:0]     w_threshold;
  logic              r_pwm;

  pwm_period_counter #(
    .PERIOD (PERIOD),
    .CW     (CW)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .i_enable (bus.enable),
    .o_count  (w_count),
    .o_zero   (w_zero)
  );

  // Duty is captured at every counter-0 cycle and held for the rest of the
  // period, so a mid-period change only shows up at the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty_shadow <= '0;
    end else if (w_zero) begin
      r_duty_shadow <= bus.duty_cycle;
    end
  end

  // On the counter-0 cycle itself the live duty is used (it is the value
  // being loaded into the shadow), so the whole period, including its first
  // cycle, runs on a single duty value and no mixed-duty pulse can appear.
  assign w_duty_eff = w_zero ? bus.duty_cycle : r_duty_shadow;

  // duty*PERIOD < 256*2^CW, so PW bits hold the full product; dropping the
  // low DUTY_W bits is the divide by 256. The result is always < PERIOD.
  assign w_product   = PW'(w_duty_eff) * PW'(PERIOD);
  assign w_threshold = w_product[PW-1:DUTY_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm <= 1'b0;
    end else if (!bus.enable) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= (w_count < w_threshold);
    end
  end

  assign bus.pwm_out = r_pwm;
  assign o_dbg_count = w_count;

endmodule : pwm_controller

// File: tb/tb_pwm_controller.sv
module tb_pwm_controller;

  localparam int P = 10;  // CLK_FREQ=1000 / PWM_FREQ=100

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_controller_if bus();
  logic [3:0] dbg_count;

  pwm_controller #(
    .CLK_FREQ (1000),
    .PWM_FREQ (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_count (dbg_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];  // {expected pwm_out, expected counter}

  // Reference model: position inside the period and the duty latched for it.
  int m_pos  = 0;
  int m_duty = 0;

  function automatic int thr(input int d);
    return (d * P) / 256;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Predict the outcome of the next clk edge from the current inputs.
  task automatic predict();
    logic e;
    if (!bus.enable) begin
      m_pos = 0;
      e = 1'b0;
    end else begin
      if (m_pos == 0) m_duty = int'(bus.duty_cycle);
      e = (m_pos < thr(m_duty));
      m_pos = (m_pos + 1) % P;
    end
    exp_q.push_back({e, 4'(m_pos)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic en, input logic [7:0] d);
    bus.enable     = en;
    bus.duty_cycle = d;
  endtask

  task automatic tick(output logic pwm);
    logic [4:0] e;
    predict();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pwm_out", 32'(bus.pwm_out), 32'(e[4]));
    check("counter", 32'(dbg_count), 32'(e[3:0]));
    pwm = bus.pwm_out;
  endtask

  task automatic run(input int n, output int highs);
    logic p;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      tick(p);
      if (p === 1'b1) highs++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   h;
    logic p;
    logic [7:0] d;

    rst = 1'b1;
    set_inputs(1'b0, 8'd0);
    #1;
    check("reset_pwm", 32'(bus.pwm_out), 32'd0);
    check("reset_count", 32'(dbg_count), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_hold_pwm", 32'(bus.pwm_out), 32'd0);
    rst = 1'b0;
    m_pos = 0; m_duty = 0;

    // duty 128 -> 5 of 10
    set_inputs(1'b1, 8'd128);
    tick(p);
    check("first_cycle_high", 32'(p), 32'd1);
    run(99, h);
    check("duty128_highs", 32'(h + 1), 32'd50);
    check("duty128_window", 32'((h + 1) >= 45 && (h + 1) <= 55), 32'd1);

    // duty 64 -> threshold 2
    set_inputs(1'b1, 8'd64);
    run(100, h);
    check("duty64_highs", 32'(h), 32'd20);
    check("duty64_window", 32'(h >= 15 && h <= 35), 32'd1);

    // duty 192 -> threshold 7
    set_inputs(1'b1, 8'd192);
    run(100, h);
    check("duty192_highs", 32'(h), 32'd70);
    check("duty192_window", 32'(h >= 65 && h <= 85), 32'd1);

    // disable while running at 192 (currently mid-period)
    run(3, h);
    set_inputs(1'b0, 8'd192);
    tick(p);
    check("disable_pwm_1clk", 32'(p), 32'd0);
    run(5, h);
    check("disable_highs", 32'(h), 32'd0);
    check("disable_count", 32'(dbg_count), 32'd0);

    // duty 0 -> never high
    set_inputs(1'b1, 8'd0);
    run(30, h);
    check("duty0_highs", 32'(h), 32'd0);

    // duty 255 -> 9 high / 1 low per period
    set_inputs(1'b1, 8'd255);
    run(10, h);
    check("duty255_period1", 32'(h), 32'd9);
    run(10, h);
    check("duty255_period2", 32'(h), 32'd9);

    // mid-period change 64 -> 255 only visible from next boundary
    set_inputs(1'b1, 8'd64);
    run(10, h);
    check("pre_change_period", 32'(h), 32'd2);
    run(3, h);
    set_inputs(1'b1, 8'd255);
    run(7, h);
    check("mid_change_rest", 32'(h), 32'd0);
    run(10, h);
    check("post_change_period", 32'(h), 32'd9);

    // reset during a high pulse, between clk edges
    set_inputs(1'b1, 8'd128);
    run(2, h);
    check("pre_reset_high", 32'(bus.pwm_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_pwm", 32'(bus.pwm_out), 32'd0);
    check("async_reset_count", 32'(dbg_count), 32'd0);
    @(posedge clk); #1;
    check("reset_held_pwm", 32'(bus.pwm_out), 32'd0);
    check("reset_held_count", 32'(dbg_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_pos = 0; m_duty = 0;
    tick(p);
    check("post_reset_first_high", 32'(p), 32'd1);
    run(9, h);
    check("post_reset_period", 32'(h + 1), 32'd5);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0:       d = 8'd0;
          1:       d = 8'd255;
          default: d = 8'($urandom_range(0, 255));
        endcase
        bus.duty_cycle = d;
      end
      bus.enable = ($urandom_range(0, 9) != 0);
      tick(p);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pwm_controller
